// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared funct codes and enums for the HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_datapath.sv
`default_nettype none
// ============================================================================
// Module   : md_datapath
// Brief    : Shift-add multiplier / restoring divider core with sign fix-up.
// Revision : 1.0 - initial release
// ============================================================================
module md_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  md_op_t           i_op,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [WIDTH-1:0] o_res_lo
);

    md_op_t             r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a_raw;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;

    assign w_abs_a = (i_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
    assign w_abs_b = (i_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;

    // Multiply: low half of r_acc holds the multiplier, consumed LSB first.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);

    // Divide: low half of r_acc holds the dividend, replaced by quotient bits.
    assign w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};
    assign w_qbit  = ~w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_rem    <= '0;
            r_m      <= '0;
            r_a_raw  <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (i_load) begin
            r_op     <= i_op;
            r_rem    <= '0;
            r_a_raw  <= i_op_a;
            r_sign_q <= i_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
            r_sign_r <= i_signed & i_op_a[WIDTH-1];
            r_dbz    <= (i_op_b == '0);
            if (i_op == OP_DIV) begin
                r_m   <= w_abs_b;
                r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
                r_m   <= w_abs_a;
                r_acc <= {{WIDTH{1'b0}}, w_abs_b};
            end
        end else if (i_step) begin
            if (r_op == OP_DIV) begin
                r_rem <= w_qbit ? w_diff : w_shift;
                r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign w_prod = r_sign_q ? -r_acc : r_acc;
    assign w_quo  = r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rmd  = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // Divide-by-zero returns the untouched dividend in HI and all-ones in LO.
    always_comb begin
        o_res_hi = w_prod[2*WIDTH-1:WIDTH];
        o_res_lo = w_prod[WIDTH-1:0];
        if (r_op == OP_DIV) begin
            o_res_hi = r_dbz ? r_a_raw : w_rmd;
            o_res_lo = r_dbz ? {WIDTH{1'b1}} : w_quo;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_multdiv
// Brief    : Iterative MULT/DIV unit owning HI/LO, with pipeline stall request.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_multdiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multdiv,
    input  logic [5:0]       function_code,
    input  logic             hi_wren,
    input  logic             lo_wren,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    md_op_t           w_op;
    logic             w_signed;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_accept = (r_state == IDLE) && multdiv && is_md_funct(function_code);
    assign w_op     = ((function_code == FN_DIV) || (function_code == FN_DIVU)) ? OP_DIV : OP_MUL;
    assign w_signed = (function_code == FN_MULT) || (function_code == FN_DIV);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == FIX);
            if (w_accept) begin
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_count <= r_count + CW'(1);
            end
            // MTHI/MTLO only land while idle; a stalled write retries after busy drops.
            if (r_state == FIX) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if ((r_state == IDLE) && !multdiv) begin
                if (hi_wren) begin
                    r_hi <= op_a;
                end
                if (lo_wren) begin
                    r_lo <= op_a;
                end
            end
        end
    end

    md_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_op     (w_op),
        .i_signed (w_signed),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo)
    );

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign stall = busy & (mfhi | mflo | multdiv | hi_wren | lo_wren);

endmodule
`default_nettype wire
